// File: rtl/output_buffer_ctrl_pkg.sv
// Shared constants for the output buffer sequencer: layer codes and FSM state encoding.
package output_buffer_ctrl_pkg;

    // MAC lanes feeding the output buffer (kept here for reference by neighbouring blocks)
    localparam int MAC_NUM = 112;

    // Layer codes driven on CS towards the output buffer
    localparam logic [3:0] SCONV_1 = 4'h1;
    localparam logic [3:0] SCONV_2 = 4'h2;
    localparam logic [3:0] SCONV_3 = 4'h3;
    localparam logic [3:0] SCONV_4 = 4'h4;

    // Sequencer state encoding
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_INIT   = 3'd1;
    localparam logic [2:0] ST_INIT_W = 3'd2;
    localparam logic [2:0] ST_ACC    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;

endpackage

// File: rtl/output_buffer_ctrl.sv
// Sequencer for the ping-pong output buffer: per group it pulses bias initialisation,
// enables accumulation over a programmed number of MAC result vectors, captures the
// final result and handshakes it to the store engine, repeating for every group.
module output_buffer_ctrl
    import output_buffer_ctrl_pkg::*;
#(
    parameter int ACC_W = 16,
    parameter int GRP_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       cs_in,
    input  logic [ACC_W-1:0] acc_len,
    input  logic [GRP_W-1:0] grp_num,
    input  logic             result_vld,
    input  logic             store_rdy,
    output logic [3:0]       CS,
    output logic             output_buffer_initial,
    output logic             en,
    output logic             store_en,
    output logic             store_vld,
    output logic             mac_go,
    output logic             busy,
    output logic             done
);

    logic [2:0]       state;
    logic [ACC_W-1:0] acc_len_q;
    logic [GRP_W-1:0] grp_num_q;
    logic [ACC_W-1:0] acc_cnt;
    logic [GRP_W-1:0] grp_cnt;
    logic             acc_last;
    logic             grp_last;

    // A zero length/count is stored as one so the last-item compares never underflow
    assign acc_last = (acc_cnt == acc_len_q - ACC_W'(1));
    assign grp_last = (grp_cnt == grp_num_q - GRP_W'(1));

    // FSM, latched layer parameters and the accumulation/group counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            CS        <= 4'h0;
            acc_len_q <= ACC_W'(1);
            grp_num_q <= GRP_W'(1);
            acc_cnt   <= '0;
            grp_cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        CS        <= cs_in;
                        acc_len_q <= (acc_len == '0) ? ACC_W'(1) : acc_len;
                        grp_num_q <= (grp_num == '0) ? GRP_W'(1) : grp_num;
                        acc_cnt   <= '0;
                        grp_cnt   <= '0;
                        state     <= ST_INIT;
                    end
                end
                ST_INIT: begin
                    state <= ST_INIT_W;
                end
                ST_INIT_W: begin
                    state <= ST_ACC;
                end
                ST_ACC: begin
                    if (result_vld) begin
                        if (acc_last) begin
                            acc_cnt <= '0;
                            state   <= ST_WB;
                        end else begin
                            acc_cnt <= acc_cnt + ACC_W'(1);
                        end
                    end
                end
                ST_WB: begin
                    if (store_rdy) begin
                        if (grp_last) begin
                            state <= ST_DONE;
                        end else begin
                            grp_cnt <= grp_cnt + GRP_W'(1);
                            state   <= ST_INIT;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Moore outputs decoded from state; store_en is the only combinational term
    always_comb begin
        output_buffer_initial = (state == ST_INIT);
        en                    = (state == ST_ACC);
        mac_go                = (state == ST_ACC);
        store_vld             = (state == ST_WB);
        busy                  = (state != ST_IDLE);
        done                  = (state == ST_DONE);
        store_en              = (state == ST_ACC) && result_vld && acc_last;
    end

endmodule

// File: tb/tb_output_buffer_ctrl.sv
// Testbench for output_buffer_ctrl: directed timing and reset checks, then randomized
// layers checked through an event scoreboard fed by a high-level layer model.
module tb_output_buffer_ctrl;
    import output_buffer_ctrl_pkg::*;

    localparam int ACC_W = 16;
    localparam int GRP_W = 10;

    localparam int EV_INIT  = 0;
    localparam int EV_STORE = 1;
    localparam int EV_HS    = 2;
    localparam int EV_DONE  = 3;

    typedef struct {
        int kind;
        int value;
    } ev_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [3:0]       cs_in;
    logic [ACC_W-1:0] acc_len;
    logic [GRP_W-1:0] grp_num;
    logic             result_vld;
    logic             store_rdy;
    logic [3:0]       CS;
    logic             output_buffer_initial;
    logic             en;
    logic             store_en;
    logic             store_vld;
    logic             mac_go;
    logic             busy;
    logic             done;

    int  total = 0;
    int  bad   = 0;
    ev_t expQ[$];
    bit  monEnable = 1'b0;
    int  doneCount = 0;

    int  vldCount;
    int  grpSeen;
    int  initAge;
    bit  storePend;
    bit  donePend;
    bit  hsPrev;

    output_buffer_ctrl #(.ACC_W(ACC_W), .GRP_W(GRP_W)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .start                (start),
        .cs_in                (cs_in),
        .acc_len              (acc_len),
        .grp_num              (grp_num),
        .result_vld           (result_vld),
        .store_rdy            (store_rdy),
        .CS                   (CS),
        .output_buffer_initial(output_buffer_initial),
        .en                   (en),
        .store_en             (store_en),
        .store_vld            (store_vld),
        .mac_go               (mac_go),
        .busy                 (busy),
        .done                 (done)
    );

    // Free-running 10 ns clock
    always #5 clk = ~clk;

    function automatic void checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endfunction

    function automatic void observe(input int kind, input int value);
        ev_t e;
        if (expQ.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected_event: got kind %0d value %0d expected none", kind, value);
        end else begin
            e = expQ.pop_front();
            checkOutput("event_kind", kind, e.kind);
            checkOutput("event_value", value, e.value);
        end
    endfunction

    function automatic int packOutputs();
        return 32'({output_buffer_initial, en, store_en, store_vld, mac_go, busy, done});
    endfunction

    // Monitor: turns DUT output activity into events for the scoreboard plus local timing checks
    always @(negedge clk) begin
        if (!monEnable || rst) begin
            vldCount  = 0;
            grpSeen   = 0;
            initAge   = 0;
            storePend = 1'b0;
            donePend  = 1'b0;
            hsPrev    = 1'b0;
        end else begin
            if (initAge == 2) begin
                checkOutput("en_two_after_init", 32'(en), 1);
                initAge = 0;
            end else if (initAge == 1) begin
                checkOutput("init_wait_quiet", 32'({en, output_buffer_initial}), 0);
                initAge = 2;
            end
            if (storePend) begin
                checkOutput("store_vld_after_store_en", 32'({store_vld, en}), 2);
                storePend = 1'b0;
            end
            if (donePend) begin
                checkOutput("busy_after_done", 32'(busy), 0);
                donePend = 1'b0;
            end
            if (output_buffer_initial) begin
                observe(EV_INIT, grpSeen);
                vldCount = 0;
                initAge  = 1;
            end
            if (en && result_vld) vldCount++;
            if (store_en) begin
                observe(EV_STORE, vldCount);
                storePend = 1'b1;
            end
            if (done) begin
                observe(EV_DONE, 32'(CS));
                checkOutput("done_after_handshake", 32'(hsPrev), 1);
                donePend = 1'b1;
                grpSeen  = 0;
                doneCount++;
            end
            hsPrev = store_vld && store_rdy;
            if (hsPrev) begin
                observe(EV_HS, grpSeen);
                grpSeen++;
            end
        end
    end

    task automatic idleInputs();
        start      = 1'b0;
        cs_in      = 4'h0;
        acc_len    = '0;
        grp_num    = '0;
        result_vld = 1'b0;
        store_rdy  = 1'b0;
    endtask

    // One layer of random traffic; expected events come from the layer's length/count rules
    task automatic applyStimulus(input logic [3:0] cs, input int len, input int grps,
                                 input int vldPct, input int rdyPct);
        int  lenEff;
        int  grpEff;
        int  doneBefore;
        int  cyc;
        ev_t e;
        lenEff = (len == 0) ? 1 : len;
        grpEff = (grps == 0) ? 1 : grps;
        for (int g = 0; g < grpEff; g++) begin
            e.kind = EV_INIT;  e.value = g;      expQ.push_back(e);
            e.kind = EV_STORE; e.value = lenEff; expQ.push_back(e);
            e.kind = EV_HS;    e.value = g;      expQ.push_back(e);
        end
        e.kind = EV_DONE; e.value = 32'(cs); expQ.push_back(e);

        doneBefore = doneCount;
        @(posedge clk); #1;
        start      = 1'b1;
        cs_in      = cs;
        acc_len    = ACC_W'(len);
        grp_num    = GRP_W'(grps);
        result_vld = ($urandom_range(0, 1) == 1);
        store_rdy  = ($urandom_range(0, 1) == 1);
        cyc = 0;
        while (doneCount == doneBefore && cyc < 4000) begin
            @(posedge clk); #1;
            if (doneCount != doneBefore) break;
            start      = busy && ($urandom_range(0, 7) == 0);
            cs_in      = 4'($urandom);
            acc_len    = ACC_W'($urandom);
            grp_num    = GRP_W'($urandom);
            result_vld = ($urandom_range(0, 99) < vldPct);
            store_rdy  = ($urandom_range(0, 99) < rdyPct);
            cyc++;
        end
        idleInputs();
        checkOutput("layer_completed", 32'(doneCount - doneBefore), 1);
        repeat (2) @(posedge clk);
    endtask

    // Directed cycle-by-cycle run: acc_len=4, one group, back-to-back results, store always ready
    task automatic runTimingTest();
        logic [6:0] expVec;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            start      = (c == 0);
            cs_in      = SCONV_2;
            acc_len    = ACC_W'(4);
            grp_num    = GRP_W'(1);
            result_vld = (c >= 3 && c <= 6);
            store_rdy  = 1'b1;
            @(negedge clk);
            expVec = {c == 1, c >= 3 && c <= 6, c == 6, c == 7, c >= 3 && c <= 6,
                      c >= 1 && c <= 8, c == 8};
            checkOutput($sformatf("timing_cycle%0d", c), packOutputs(), 32'(expVec));
        end
        checkOutput("timing_cs_latched", 32'(CS), 32'(SCONV_2));
        idleInputs();
    endtask

    // Directed reset in the middle of accumulation after five results
    task automatic runResetTest();
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            start      = (c == 0);
            cs_in      = SCONV_3;
            acc_len    = ACC_W'(10);
            grp_num    = GRP_W'(1);
            result_vld = (c >= 3);
            store_rdy  = 1'b0;
        end
        @(posedge clk); #1;
        checkOutput("pre_reset_in_acc", 32'({en, busy}), 3);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("mid_acc_reset_outputs", packOutputs(), 0);
        checkOutput("mid_acc_reset_cs", 32'(CS), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        idleInputs();
        repeat (2) @(posedge clk);
    endtask

    // Main sequence
    initial begin
        rst = 1'b1;
        idleInputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_outputs", packOutputs(), 0);
        checkOutput("reset_cs", 32'(CS), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        runTimingTest();
        repeat (2) @(posedge clk);
        runResetTest();

        $display("[TB] starting randomized layers");
        monEnable = 1'b1;
        applyStimulus(SCONV_1, 4, 1, 100, 100);
        applyStimulus(SCONV_2, 3, 2, 50, 100);
        applyStimulus(SCONV_3, 0, 0, 60, 50);
        applyStimulus(SCONV_4, 5, 3, 70, 15);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(4'($urandom_range(1, 15)), $urandom_range(0, 8),
                          $urandom_range(0, 4), $urandom_range(20, 100),
                          $urandom_range(10, 100));
        end
        checkOutput("scoreboard_drained", expQ.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
